// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register enables/flushes and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs1;
  logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs2;
  logic                                id_rs1_used;
  logic                                id_rs2_used;
  logic [pipe_ctrl_pkg::REG_IDX_W-1:0] ex_rd;
  logic                                ex_rd_wren;
  logic                                ex_is_load;
  logic                                ex_br_taken;
  logic                                mem_req;
  logic                                mem_ack;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_rd_wren,
           ex_is_load, ex_br_taken, mem_req, mem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, mem_err, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_rd_wren,
           ex_is_load, ex_br_taken, mem_req, mem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, mem_err, state_o, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator between the EX load and the ID operands.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_rd_wren,
  input  logic                 ex_is_load,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    // x0 is never a real producer, so it cannot create a dependency
    load_use = ex_is_load && ex_rd_wren && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/stall controller: load-use, branch flush, memory wait
// with watchdog, and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic load_use;
  logic mem_stall;
  logic freeze;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic do_stall, do_flush;

  load_use_detect u_load_use_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .ex_rd       (bus.ex_rd),
    .ex_rd_wren  (bus.ex_rd_wren),
    .ex_is_load  (bus.ex_is_load),
    .load_use    (load_use)
  );

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;
    do_flush     = 1'b0;
    mem_stall    = bus.mem_req && !bus.mem_ack;
    // the acking MEM_WAIT cycle falls through to the normal RUN decode
    freeze       = ((state == ST_RUN) && mem_stall) ||
                   ((state == ST_MEM_WAIT) && !bus.mem_ack);
    if (rst) begin
      // everything stays low
    end else if (state == ST_ERR) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      mem_err      = 1'b1;
    end else if (freeze) begin
      memwb_bubble = 1'b1;
    end else if (bus.ex_br_taken) begin
      // branch beats load-use: the stalled instruction is wrong-path anyway
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      do_flush   = 1'b1;
    end else if (load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
    do_stall = !rst && (state != ST_ERR) && !pc_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ack) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ST_ERR: ;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
      if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (do_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.mem_err      = mem_err;
  assign bus.state_o      = rst ? 2'b00 : state;
  assign bus.stall_cnt    = rst ? '0 : stall_cnt_q;
  assign bus.flush_cnt    = rst ? '0 : flush_cnt_q;

endmodule
